// File: rtl/add_q_pkg.sv
// Shared definitions for the adder result queue.
// Holds the default sizing, the queue entry layout and the saturation
// constants for the default 32-bit datapath.
package add_q_pkg;

   localparam int NUM_DEFAULT        = 32;
   localparam int ADDQ_DEPTH_DEFAULT = 4;
   localparam int TAG_W_DEFAULT      = 5;

   // Saturation values for the default datapath width
   localparam logic [NUM_DEFAULT-1:0] SAT_MAX_S = {1'b0, {(NUM_DEFAULT-1){1'b1}}};
   localparam logic [NUM_DEFAULT-1:0] SAT_MIN_S = {1'b1, {(NUM_DEFAULT-1){1'b0}}};
   localparam logic [NUM_DEFAULT-1:0] SAT_MAX_U = {NUM_DEFAULT{1'b1}};

   // One queued adder result; the queue packs entries in this field order
   typedef struct packed {
      logic [NUM_DEFAULT-1:0]   data;
      logic                     ovf;
      logic [TAG_W_DEFAULT-1:0] tag;
   } add_q_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO used to buffer adder results.
// Pointers wrap modulo DEPTH and each carries a wrap bit, so full and
// empty are told apart without a separate occupancy register.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   localparam int CW   = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic [CW-1:0]    count,
   output logic             full,
   output logic             empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [AW-1:0]    wr_idx;
   logic [AW-1:0]    rd_idx;
   logic             wr_wrap;
   logic             rd_wrap;
   logic             do_pop;
   logic [WIDTH-1:0] mem [DEPTH];

   assign empty  = (wr_idx == rd_idx) && (wr_wrap == rd_wrap);
   assign full   = (wr_idx == rd_idx) && (wr_wrap != rd_wrap);
   assign do_pop = pop & ~empty;

   // Head is forced to zero when empty so stale storage never shows
   assign dout = empty ? '0 : mem[rd_idx];

   // Occupancy derived from the two pointers and their wrap bits
   always_comb begin
      count = CW'(wr_idx) - CW'(rd_idx);
      if (wr_wrap != rd_wrap) begin
         count = CW'(DEPTH) + CW'(wr_idx) - CW'(rd_idx);
      end
   end

   // Write and read pointers, each wrapping at DEPTH and toggling its wrap bit
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_idx  <= '0;
         wr_wrap <= 1'b0;
         rd_idx  <= '0;
         rd_wrap <= 1'b0;
      end else begin
         if (push) begin
            if (wr_idx == AW'(DEPTH - 1)) begin
               wr_idx  <= '0;
               wr_wrap <= ~wr_wrap;
            end else begin
               wr_idx <= wr_idx + 1'b1;
            end
         end
         if (do_pop) begin
            if (rd_idx == AW'(DEPTH - 1)) begin
               rd_idx  <= '0;
               rd_wrap <= ~rd_wrap;
            end else begin
               rd_idx <= rd_idx + 1'b1;
            end
         end
      end
   end

   // Storage array; contents need no reset because the head is gated by empty
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_idx] <= din;
      end
   end

endmodule

// File: rtl/add_result_queue.sv
// Result queue sitting behind the registered adder.
// Tracks each issued add for one cycle, captures the registered sum and
// overflow tagged with the destination, and buffers them toward writeback.
// Credits (count plus the pending slot) keep the FIFO from ever overflowing.
// Optional macro ADDQ_SAT_EN saturates overflowing results on push.
module add_result_queue
   import add_q_pkg::*;
#(
   parameter int NUM   = NUM_DEFAULT,
   parameter int DEPTH = ADDQ_DEPTH_DEFAULT,
   parameter int TAG_W = TAG_W_DEFAULT,
   localparam int CW   = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             issue_valid,
   output logic             issue_ready,
   input  logic [TAG_W-1:0] issue_tag,
   input  logic             issue_sign,
   input  logic [NUM-1:0]   add_s,
   input  logic             add_ovf,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [NUM-1:0]   out_data,
   output logic             out_ovf,
   output logic [TAG_W-1:0] out_tag,
   output logic             ovf_sticky,
   input  logic             ovf_clr,
   output logic [CW-1:0]    count
);

   localparam int EW = NUM + 1 + TAG_W;

   logic             p_valid;
   logic [TAG_W-1:0] p_tag;
   logic             p_sign;
   logic             fire;
   logic             push;
   logic             pop;
   logic             fifo_full;
   logic             fifo_empty;
   logic [NUM-1:0]   push_data;
   logic [EW-1:0]    push_entry;
   logic [EW-1:0]    head_entry;
   logic [CW:0]      credits_used;

   // Credits come from registers only, so out_ready never reaches issue_ready
   assign credits_used = {1'b0, count} + {{CW{1'b0}}, p_valid};
   assign issue_ready  = credits_used < (CW+1)'(DEPTH);
   assign fire         = issue_valid & issue_ready;
   assign push         = p_valid;
   assign out_valid    = ~fifo_empty;
   assign pop          = out_valid & out_ready;
   assign push_entry   = {push_data, add_ovf, p_tag};
   assign {out_data, out_ovf, out_tag} = head_entry;

   // Pending stage remembers the issued add until its registered sum arrives
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         p_valid <= 1'b0;
         p_tag   <= '0;
         p_sign  <= 1'b0;
      end else begin
         p_valid <= fire;
         if (fire) begin
            p_tag  <= issue_tag;
            p_sign <= issue_sign;
         end
      end
   end

`ifdef ADDQ_SAT_EN
   // Clamp overflowing sums to the extreme of their signed or unsigned range
   always_comb begin
      push_data = add_s;
      if (add_ovf) begin
         if (!p_sign) begin
            push_data = '1;
         end else if (add_s[NUM-1]) begin
            push_data = {1'b0, {(NUM-1){1'b1}}};
         end else begin
            push_data = {1'b1, {(NUM-1){1'b0}}};
         end
      end
   end
`else
   logic unused_sign;
   assign unused_sign = p_sign;

   // Without saturation the wrapped sum is queued unchanged
   always_comb begin
      push_data = add_s;
   end
`endif

   // Sticky overflow flag; a captured overflow wins over a same-cycle clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf_sticky <= 1'b0;
      end else if (push && add_ovf) begin
         ovf_sticky <= 1'b1;
      end else if (ovf_clr) begin
         ovf_sticky <= 1'b0;
      end
   end

   sync_fifo #(
      .WIDTH (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (push_entry),
      .dout  (head_entry),
      .count (count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // The credit scheme makes a push into a full FIFO impossible
   assert property (@(posedge clk) disable iff (rst) !(push && fifo_full));

endmodule

// File: tb/tb_add_result_queue.sv
// Directed testbench for add_result_queue.
// A registered adder stand-in feeds add_s/add_ovf one cycle after each issue.
module tb_add_result_queue;
   import add_q_pkg::*;

   localparam int NUM   = 32;
   localparam int DEPTH = 4;
   localparam int TAG_W = 5;
   localparam int CW    = $clog2(DEPTH + 1);

   logic             clk = 1'b0;
   logic             rst;
   logic             issue_valid;
   logic             issue_ready;
   logic [TAG_W-1:0] issue_tag;
   logic             issue_sign;
   logic [NUM-1:0]   add_s;
   logic             add_ovf;
   logic             out_valid;
   logic             out_ready;
   logic [NUM-1:0]   out_data;
   logic             out_ovf;
   logic [TAG_W-1:0] out_tag;
   logic             ovf_sticky;
   logic             ovf_clr;
   logic [CW-1:0]    count;

   logic [NUM-1:0]   op_a;
   logic [NUM-1:0]   op_b;

   int total = 0;
   int bad   = 0;

   add_result_queue #(
      .NUM   (NUM),
      .DEPTH (DEPTH),
      .TAG_W (TAG_W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .issue_valid (issue_valid),
      .issue_ready (issue_ready),
      .issue_tag   (issue_tag),
      .issue_sign  (issue_sign),
      .add_s       (add_s),
      .add_ovf     (add_ovf),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_ovf     (out_ovf),
      .out_tag     (out_tag),
      .ovf_sticky  (ovf_sticky),
      .ovf_clr     (ovf_clr),
      .count       (count)
   );

   always #5 clk = ~clk;

   // Registered adder stand-in: sum and signed/unsigned overflow
   always @(posedge clk) begin
      logic [NUM:0] wide;
      wide = {1'b0, op_a} + {1'b0, op_b};
      add_s <= wide[NUM-1:0];
      if (issue_sign) begin
         add_ovf <= (op_a[NUM-1] == op_b[NUM-1]) && (wide[NUM-1] != op_a[NUM-1]);
      end else begin
         add_ovf <= wide[NUM];
      end
   end

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [TAG_W-1:0] t, input logic s,
                                input logic [NUM-1:0] a, input logic [NUM-1:0] b);
      issue_valid = v;
      issue_tag   = t;
      issue_sign  = s;
      op_a        = a;
      op_b        = b;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog got=timeout exp=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int accepted;
      rst       = 1'b1;
      out_ready = 1'b0;
      ovf_clr   = 1'b0;
      applyStimulus(1'b0, '0, 1'b0, '0, '0);
      step();
      step();
      rst = 1'b0;
      step();

      // Reset state
      checkOutput("rst_out_valid", out_valid, 0);
      checkOutput("rst_issue_ready", issue_ready, 1);
      checkOutput("rst_count", count, 0);
      checkOutput("rst_out_data", out_data, 0);
      checkOutput("rst_out_tag", out_tag, 0);
      checkOutput("rst_sticky", ovf_sticky, 0);

      // Single issue: 2+3, tag 7
      applyStimulus(1'b1, 5'd7, 1'b0, 32'd2, 32'd3);
      step();
      applyStimulus(1'b0, '0, 1'b0, '0, '0);
      checkOutput("single_c1_valid", out_valid, 0);
      step();
      checkOutput("single_c2_valid", out_valid, 1);
      checkOutput("single_data", out_data, 32'h5);
      checkOutput("single_tag", out_tag, 7);
      checkOutput("single_ovf", out_ovf, 0);
      checkOutput("single_count", count, 1);
      step();
      checkOutput("single_hold_data", out_data, 32'h5);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      checkOutput("single_pop_count", count, 0);

      // Signed overflow with a clear on the same push edge
      applyStimulus(1'b1, 5'd3, 1'b1, 32'h7FFF_FFFF, 32'h1);
      step();
      applyStimulus(1'b0, '0, 1'b0, '0, '0);
      ovf_clr = 1'b1;
      step();
      ovf_clr = 1'b0;
      checkOutput("sovf_valid", out_valid, 1);
      checkOutput("sovf_ovf", out_ovf, 1);
      checkOutput("sovf_sticky", ovf_sticky, 1);
      checkOutput("sovf_tag", out_tag, 3);
`ifdef ADDQ_SAT_EN
      checkOutput("sovf_data", out_data, 32'h7FFF_FFFF);
`else
      checkOutput("sovf_data", out_data, 32'h8000_0000);
`endif
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      ovf_clr   = 1'b1;
      step();
      ovf_clr = 1'b0;
      checkOutput("sticky_cleared", ovf_sticky, 0);

      // Unsigned carry
      applyStimulus(1'b1, 5'd9, 1'b0, 32'hFFFF_FFFF, 32'h2);
      step();
      applyStimulus(1'b0, '0, 1'b0, '0, '0);
      step();
      checkOutput("uovf_ovf", out_ovf, 1);
      checkOutput("uovf_sticky", ovf_sticky, 1);
      checkOutput("uovf_tag", out_tag, 9);
`ifdef ADDQ_SAT_EN
      checkOutput("uovf_data", out_data, 32'hFFFF_FFFF);
`else
      checkOutput("uovf_data", out_data, 32'h1);
`endif
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      ovf_clr   = 1'b1;
      step();
      ovf_clr = 1'b0;

      // Backpressure: issue every cycle with the consumer stalled
      accepted = 0;
      for (int c = 0; c < 8; c++) begin
         applyStimulus(1'b1, 5'(10 + c), 1'b0, 32'(c), 32'd0);
         if (c == 4) checkOutput("bp_ready_low", issue_ready, 0);
         if (issue_ready) accepted++;
         step();
      end
      applyStimulus(1'b0, '0, 1'b0, '0, '0);
      checkOutput("bp_accepted", accepted, 4);
      checkOutput("bp_count_full", count, 4);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         checkOutput("bp_drain_tag", out_tag, 10 + i);
         checkOutput("bp_drain_data", out_data, i);
         if (i == 0) checkOutput("bp_ready_before_pop", issue_ready, 0);
         step();
         if (i == 0) checkOutput("bp_ready_after_pop", issue_ready, 1);
      end
      checkOutput("bp_empty", out_valid, 0);

      // Streaming: 16 back-to-back issues with the consumer always ready
      for (int t = 0; t < 18; t++) begin
         if (t < 16) applyStimulus(1'b1, 5'(t), 1'b0, 32'(t), 32'd100);
         else        applyStimulus(1'b0, '0, 1'b0, '0, '0);
         checkOutput("stream_count_le1", (count <= 1), 1);
         if (t < 2) begin
            checkOutput("stream_early_valid", out_valid, 0);
         end else begin
            checkOutput("stream_valid", out_valid, 1);
            checkOutput("stream_tag", out_tag, t - 2);
            checkOutput("stream_data", out_data, t - 2 + 100);
         end
         step();
      end
      checkOutput("stream_done", out_valid, 0);
      out_ready = 1'b0;

      // Reset mid-flight with results buffered and one pending
      for (int c = 0; c < 4; c++) begin
         applyStimulus(1'b1, 5'(20 + c), 1'b0, 32'(c), 32'd1);
         step();
      end
      applyStimulus(1'b0, '0, 1'b0, 32'h1234, 32'h1);
      checkOutput("mid_count3", count, 3);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("mid_rst_valid", out_valid, 0);
      checkOutput("mid_rst_count", count, 0);
      checkOutput("mid_rst_ready", issue_ready, 1);
      checkOutput("mid_rst_data", out_data, 0);
      step();
      rst = 1'b0;
      step();
      step();
      checkOutput("post_rst_count", count, 0);
      checkOutput("post_rst_valid", out_valid, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
